// File: rtl/sys_cmd_ctrl_pkg.sv
// Command codes, operand addresses and FSM state encoding for the
// command-frame controller.
package sys_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // ALU operands live in the first two register-file locations
    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_ALU_A,
        S_ALU_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_SEND_LO,
        S_SEND_HI
    } state_t;

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// Bus bundle between the command controller and its neighbours: RX byte
// stream in, register file and ALU control out, reply bytes to the TX FIFO.
interface sys_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic [DATA_WIDTH-1:0]   RdData;
    logic                    RdData_Valid;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    OUT_Valid;
    logic                    FIFO_FULL;
    logic                    WrEn;
    logic                    RdEn;
    logic [ADDR_WIDTH-1:0]   Address;
    logic [DATA_WIDTH-1:0]   WrData;
    logic                    ALU_EN;
    logic [3:0]              ALU_FUN;
    logic                    CLK_EN;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    FRAME_ERR;

    // controller side
    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN,
               TX_P_DATA, TX_D_VLD, FRAME_ERR
    );

    // environment side (synchroniser, register file, ALU, TX FIFO)
    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN,
               TX_P_DATA, TX_D_VLD, FRAME_ERR
    );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Command-frame controller: parses AA/BB/CC/DD frames from the synchronised
// RX byte stream, drives register-file and ALU strobes, and returns read/ALU
// results to the TX FIFO under FIFO_FULL back-pressure.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  S_IDLE     | waiting for a command byte
//  S_WR_ADDR  | write frame, waiting for address byte
//  S_WR_DATA  | write frame, waiting for data byte
//  S_RD_ADDR  | read frame, waiting for address byte
//  S_RD_WAIT  | read issued, waiting for RdData_Valid (timed)
//  S_ALU_A    | ALU frame, waiting for operand A (stored at OPA_ADDR)
//  S_ALU_B    | ALU frame, waiting for operand B (stored at OPB_ADDR)
//  S_ALU_FUN  | waiting for function byte, ALU clock enabled
//  S_ALU_WAIT | ALU started, waiting for OUT_Valid (timed)
//  S_SEND_LO  | offering result low byte to TX FIFO
//  S_SEND_HI  | offering result high byte to TX FIFO (ALU replies only)
module sys_cmd_ctrl
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              CLK,
    input  logic              RST,
    sys_cmd_ctrl_if.master    bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [2*DATA_WIDTH-1:0] result, result_nxt;
    logic                    is_alu, is_alu_nxt;
    logic [ADDR_WIDTH-1:0]   addr_lat, addr_lat_nxt;

    logic                    wr_en_q, wr_en_nxt;
    logic                    rd_en_q, rd_en_nxt;
    logic [ADDR_WIDTH-1:0]   address_q, address_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_nxt;
    logic                    alu_en_q, alu_en_nxt;
    logic [3:0]              alu_fun_q, alu_fun_nxt;
    logic                    clk_en_q, clk_en_nxt;
    logic                    err_q, err_nxt;

    logic                    rx;
    logic [DATA_WIDTH-1:0]   rx_byte;
    logic                    tx_vld;
    logic                    sending;

    assign rx      = bus.RX_D_VLD;
    assign rx_byte = bus.RX_P_DATA;
    assign sending = (state == S_SEND_LO) || (state == S_SEND_HI);
    assign tx_vld  = sending && !bus.FIFO_FULL;

    // State, timer, result and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            result    <= '0;
            is_alu    <= 1'b0;
            addr_lat  <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            address_q <= '0;
            wr_data_q <= '0;
            alu_en_q  <= 1'b0;
            alu_fun_q <= '0;
            clk_en_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            result    <= result_nxt;
            is_alu    <= is_alu_nxt;
            addr_lat  <= addr_lat_nxt;
            wr_en_q   <= wr_en_nxt;
            rd_en_q   <= rd_en_nxt;
            address_q <= address_nxt;
            wr_data_q <= wr_data_nxt;
            alu_en_q  <= alu_en_nxt;
            alu_fun_q <= alu_fun_nxt;
            clk_en_q  <= clk_en_nxt;
            err_q     <= err_nxt;
        end
    end

    // Next-state decode and next values of the registered outputs
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        result_nxt   = result;
        is_alu_nxt   = is_alu;
        addr_lat_nxt = addr_lat;
        wr_en_nxt    = 1'b0;
        rd_en_nxt    = 1'b0;
        alu_en_nxt   = 1'b0;
        err_nxt      = 1'b0;
        address_nxt  = address_q;
        wr_data_nxt  = wr_data_q;
        alu_fun_nxt  = alu_fun_q;

        case (state)
            S_IDLE: begin
                if (rx) begin
                    case (rx_byte[7:0])
                        CMD_WR:      state_nxt = S_WR_ADDR;
                        CMD_RD:      state_nxt = S_RD_ADDR;
                        CMD_ALU_OP:  state_nxt = S_ALU_A;
                        CMD_ALU_NOP: state_nxt = S_ALU_FUN;
                        default:     err_nxt   = 1'b1;
                    endcase
                end
            end
            S_WR_ADDR: begin
                if (rx) begin
                    addr_lat_nxt = rx_byte[ADDR_WIDTH-1:0];
                    state_nxt    = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (rx) begin
                    wr_en_nxt   = 1'b1;
                    address_nxt = addr_lat;
                    wr_data_nxt = rx_byte;
                    state_nxt   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (rx) begin
                    rd_en_nxt   = 1'b1;
                    address_nxt = rx_byte[ADDR_WIDTH-1:0];
                    cnt_nxt     = '0;
                    state_nxt   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // a valid on the terminal cycle still wins over the timeout
                if (bus.RdData_Valid) begin
                    result_nxt = {{DATA_WIDTH{1'b0}}, bus.RdData};
                    is_alu_nxt = 1'b0;
                    state_nxt  = S_SEND_LO;
                end else if (cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_ALU_A: begin
                if (rx) begin
                    wr_en_nxt   = 1'b1;
                    address_nxt = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_nxt = rx_byte;
                    state_nxt   = S_ALU_B;
                end
            end
            S_ALU_B: begin
                if (rx) begin
                    wr_en_nxt   = 1'b1;
                    address_nxt = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_nxt = rx_byte;
                    state_nxt   = S_ALU_FUN;
                end
            end
            S_ALU_FUN: begin
                if (rx) begin
                    alu_en_nxt  = 1'b1;
                    alu_fun_nxt = rx_byte[3:0];
                    cnt_nxt     = '0;
                    state_nxt   = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                if (bus.OUT_Valid) begin
                    result_nxt = bus.ALU_OUT;
                    is_alu_nxt = 1'b1;
                    state_nxt  = S_SEND_LO;
                end else if (cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_SEND_LO: begin
                if (tx_vld) state_nxt = is_alu ? S_SEND_HI : S_IDLE;
            end
            S_SEND_HI: begin
                if (tx_vld) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // bytes arriving while a reply is pending are dropped and flagged
        if (rx && ((state == S_RD_WAIT) || (state == S_ALU_WAIT) || sending))
            err_nxt = 1'b1;

        clk_en_nxt = (state_nxt == S_ALU_FUN) || (state_nxt == S_ALU_WAIT);
    end

    // Output drive: registered strobes plus the combinational TX path
    always_comb begin
        bus.WrEn      = wr_en_q;
        bus.RdEn      = rd_en_q;
        bus.Address   = address_q;
        bus.WrData    = wr_data_q;
        bus.ALU_EN    = alu_en_q;
        bus.ALU_FUN   = alu_fun_q;
        bus.CLK_EN    = clk_en_q;
        bus.FRAME_ERR = err_q;
        bus.TX_D_VLD  = tx_vld;
        bus.TX_P_DATA = '0;
        if (state == S_SEND_LO)      bus.TX_P_DATA = result[DATA_WIDTH-1:0];
        else if (state == S_SEND_HI) bus.TX_P_DATA = result[2*DATA_WIDTH-1:DATA_WIDTH];
    end

endmodule
